// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory stage.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic SZ_WORD = 1'b0;
   localparam logic SZ_BYTE = 1'b1;

   // Little-endian lane pick: lane 0 is bits 7:0.
   function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] lane);
      return w[{lane, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/dmem_wait_cnt.sv
// Wait-state counter: loads on request acceptance, counts down to zero.
module dmem_wait_cnt #(
   parameter int W = 1
) (
   input  logic         gclk,
   input  logic         grst_n,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n)                 cnt <= '0;
      else if (load)               cnt <= load_val;
      else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage: word/byte load/store with programmable wait states.
// Define DMEM_BYTE_SIGNEXT_EN to sign-extend byte loads (zero-extend otherwise).
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYC    = 2
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   input  logic        mRD,
   input  logic        mWR,
   input  logic        ByteOp,
   output logic [31:0] DataOut,
   output logic        Busy,
   output logic        Done,
   output logic        Err
);

   localparam int AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW  = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
   localparam int LDV = (WAIT_CYC > 0) ? WAIT_CYC - 1 : 0;

   state_t      state, nxt;
   logic        req, accept, commit, expired;
   logic [31:0] addr_q, wdata_q;
   logic        rd_q, wr_q, byte_q;
   logic [31:0] c_addr, c_wdata, c_load;
   logic        c_rd, c_wr, c_byte, c_err;
   logic [AW-1:0] c_idx;
   logic [1:0]  c_lane;
   logic [7:0]  c_bval;
   logic [31:0] mem [DEPTH_WORDS];

   assign req  = mRD | mWR;
   assign Busy = (state == WAIT) | ((state == IDLE) & req);

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt    = state;
      accept = 1'b0;
      commit = 1'b0;
      case (state)
         IDLE: if (req) begin
            accept = 1'b1;
            if (WAIT_CYC == 0) begin
               nxt    = DONE;
               commit = 1'b1;
            end else begin
               nxt    = WAIT;
            end
         end
         WAIT: if (expired) begin
            nxt    = DONE;
            commit = 1'b1;
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   dmem_wait_cnt #(.W(CW)) u_wait_cnt (
      .gclk     (CLK),
      .grst_n   (Reset),
      .load     (accept),
      .dec      (state == WAIT),
      .load_val (CW'(LDV)),
      .expired  (expired)
   );

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         byte_q  <= 1'b0;
      end else if (accept) begin
         addr_q  <= Addr;
         wdata_q <= WriteData;
         rd_q    <= mRD;
         wr_q    <= mWR;
         byte_q  <= ByteOp;
      end
   end

   // With zero wait states the commit edge is the acceptance edge, so the live inputs feed it.
   always_comb begin
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_rd    = rd_q;
      c_wr    = wr_q;
      c_byte  = byte_q;
      if (state == IDLE) begin
         c_addr  = Addr;
         c_wdata = WriteData;
         c_rd    = mRD;
         c_wr    = mWR;
         c_byte  = ByteOp;
      end
      c_err  = (c_rd & c_wr)
             | ((c_byte == SZ_WORD) & (c_addr[1:0] != 2'b00))
             | ({2'b00, c_addr[31:2]} >= 32'(DEPTH_WORDS));
      c_idx  = c_addr[AW+1:2];
      c_lane = c_addr[1:0];
      c_bval = lane_sel(mem[c_idx], c_lane);
`ifdef DMEM_BYTE_SIGNEXT_EN
      c_load = (c_byte == SZ_BYTE) ? {{24{c_bval[7]}}, c_bval} : mem[c_idx];
`else
      c_load = (c_byte == SZ_BYTE) ? {24'h0, c_bval} : mem[c_idx];
`endif
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
         DataOut <= '0;
         Done    <= 1'b0;
         Err     <= 1'b0;
      end else begin
         Done <= commit;
         Err  <= commit & c_err;
         if (commit && !c_err && c_wr) begin
            if (c_byte == SZ_BYTE) mem[c_idx][{c_lane, 3'b000} +: 8] <= c_wdata[7:0];
            else                   mem[c_idx] <= c_wdata;
         end
         if (commit && c_rd) DataOut <= c_err ? 32'h0 : c_load;
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed plan steps plus random accesses vs. a memory model.
module tb_data_mem_ctrl;

   localparam int DEPTH = 64;
   localparam int WC    = 2;

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;
   logic [31:0] Addr = '0, WriteData = '0;
   logic        mRD = 1'b0, mWR = 1'b0, ByteOp = 1'b0;
   logic [31:0] DataOut;
   logic        Busy, Done, Err;

   logic [31:0] z_addr = '0, z_wd = '0;
   logic        z_rd = 1'b0, z_wr = 1'b0, z_bo = 1'b0;
   logic [31:0] z_dout;
   logic        z_busy, z_done, z_err;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] mmem [DEPTH];
   logic [31:0] mdout = '0;

   always #5 CLK = ~CLK;

   data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYC(WC)) dut (
      .CLK(CLK), .Reset(Reset), .Addr(Addr), .WriteData(WriteData),
      .mRD(mRD), .mWR(mWR), .ByteOp(ByteOp),
      .DataOut(DataOut), .Busy(Busy), .Done(Done), .Err(Err)
   );

   data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYC(0)) dut0 (
      .CLK(CLK), .Reset(Reset), .Addr(z_addr), .WriteData(z_wd),
      .mRD(z_rd), .mWR(z_wr), .ByteOp(z_bo),
      .DataOut(z_dout), .Busy(z_busy), .Done(z_done), .Err(z_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One access on the WAIT_CYC=2 instance, checked against the array model.
   task automatic acc(input logic [31:0] a, input logic [31:0] wd,
                      input logic rd, input logic wr, input logic bo);
      logic       err;
      logic [7:0] b;
      int         idx, lane, n, busy_n;
      err  = (rd && wr) || (!bo && a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
      idx  = int'(a >> 2);
      lane = int'(a[1:0]);
      if (!err) begin
         if (wr) begin
            if (bo) mmem[idx][8*lane +: 8] = wd[7:0];
            else    mmem[idx] = wd;
         end
         if (rd) begin
            if (bo) begin
               b = mmem[idx][8*lane +: 8];
`ifdef DMEM_BYTE_SIGNEXT_EN
               mdout = {{24{b[7]}}, b};
`else
               mdout = {24'h0, b};
`endif
            end else begin
               mdout = mmem[idx];
            end
         end
      end else if (rd) begin
         mdout = 32'h0;
      end

      @(negedge CLK);
      Addr = a; WriteData = wd; mRD = rd; mWR = wr; ByteOp = bo;
      #1 chk("busy_req_cycle", 32'(Busy), 32'd1);
      @(posedge CLK);
      #1;
      mRD = 1'b0; mWR = 1'b0;
      Addr = $urandom; WriteData = $urandom; ByteOp = 1'($urandom);
      n = 0; busy_n = 1;
      while (n < 20) begin
         @(negedge CLK);
         n++;
         if (Done) break;
         busy_n += int'(Busy);
      end
      chk("done_latency", 32'(n), 32'(WC + 1));
      chk("busy_cycles", 32'(busy_n), 32'(WC + 1));
      chk("busy_in_done", 32'(Busy), 32'd0);
      chk("err", 32'(Err), 32'(err));
      chk("dataout", DataOut, mdout);
      @(negedge CLK);
      chk("done_drop", 32'(Done), 32'd0);
      chk("err_drop", 32'(Err), 32'd0);
      chk("dataout_hold", DataOut, mdout);
   endtask

   initial begin
      int          nd;
      logic [31:0] zv [3];
      logic [31:0] za [6];
      logic        zw [6];
      for (int i = 0; i < DEPTH; i++) mmem[i] = '0;

      #2;
      chk("rst_dataout", DataOut, 32'h0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_err", 32'(Err), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      @(negedge CLK);
      Reset = 1'b1;

      // 1: word store / load
      acc(32'h8, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
      acc(32'h8, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("t1_load", DataOut, 32'hDEADBEEF);

      // 2: byte lane store / load
      acc(32'h8, 32'h0, 1'b0, 1'b1, 1'b0);
      acc(32'h9, 32'hFFFFFF80, 1'b0, 1'b1, 1'b1);
      acc(32'h9, 32'h0, 1'b1, 1'b0, 1'b1);
`ifdef DMEM_BYTE_SIGNEXT_EN
      chk("t2_byte_load", DataOut, 32'hFFFFFF80);
`else
      chk("t2_byte_load", DataOut, 32'h00000080);
`endif
      acc(32'h8, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("t2_word_load", DataOut, 32'h00008000);

      // 3/4: errors leave memory alone
      acc(32'h0, 32'hA5A50F0F, 1'b0, 1'b1, 1'b0);
      acc(32'h6, 32'h0, 1'b1, 1'b0, 1'b0);
      acc(32'h100, 32'h11112222, 1'b0, 1'b1, 1'b0);
      acc(32'h0, 32'h33334444, 1'b1, 1'b1, 1'b0);
      acc(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("t4_word0_kept", DataOut, 32'hA5A50F0F);

      // 5: reset in the WAIT cycle
      @(negedge CLK);
      Addr = 32'h4; WriteData = 32'h12345678; mWR = 1'b1; ByteOp = 1'b0;
      @(posedge CLK);
      #1 mWR = 1'b0;
      @(negedge CLK);
      Reset = 1'b0;
      #1;
      chk("t5_rst_dataout", DataOut, 32'h0);
      chk("t5_rst_busy", 32'(Busy), 32'd0);
      chk("t5_rst_done", 32'(Done), 32'd0);
      @(negedge CLK);
      Reset = 1'b1;
      for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
      mdout = '0;
      nd = 0;
      repeat (5) begin
         @(negedge CLK);
         nd += int'(Done);
      end
      chk("t5_no_done", 32'(nd), 32'd0);
      acc(32'h4, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("t5_load_after_rst", DataOut, 32'h0);

      // random traffic
      for (int k = 0; k < 40; k++) begin
         logic [31:0] a;
         logic        bo, rd, wr;
         int          op, lane;
         bo   = 1'($urandom_range(0, 1));
         lane = $urandom_range(0, 3);
         if (!bo && $urandom_range(0, 3) != 0) lane = 0;
         a    = (32'($urandom_range(0, 69)) << 2) | 32'(lane);
         op   = $urandom_range(0, 9);
         rd   = (op == 0) || (op >= 5);
         wr   = (op <= 4);
         acc(a, $urandom, rd, wr, bo);
      end

      // 6: zero wait states, requests held back to back
      for (int i = 0; i < 3; i++) zv[i] = $urandom;
      for (int i = 0; i < 6; i++) begin
         za[i] = 32'((i % 3) * 4);
         zw[i] = (i < 3);
      end
      @(negedge CLK);
      z_addr = za[0]; z_wd = zv[0]; z_wr = 1'b1; z_rd = 1'b0; z_bo = 1'b0;
      #1 chk("t6_busy_idle", 32'(z_busy), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         chk("t6_done", 32'(z_done), 32'd1);
         chk("t6_busy_done", 32'(z_busy), 32'd0);
         chk("t6_err", 32'(z_err), 32'd0);
         if (!zw[i]) chk("t6_load", z_dout, zv[i % 3]);
         if (i < 5) begin
            z_addr = za[i+1]; z_wd = zv[(i+1) % 3];
            z_wr = zw[i+1]; z_rd = !zw[i+1];
         end else begin
            z_wr = 1'b0; z_rd = 1'b0;
         end
         @(negedge CLK);
         chk("t6_done_gap", 32'(z_done), 32'd0);
         if (i < 5) chk("t6_busy_idle", 32'(z_busy), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
